// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants and state/owner encodings for the memory
//               port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int unsigned C_DEFAULT_ADDR_WIDTH = 32;
    localparam int unsigned C_DEFAULT_BIT_WIDTH  = 32;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_e;

    // Which requester owns the shared port for the current transaction
    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arb_owner_e;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates one shared memory port between a read-only
//               instruction-fetch requester and a data-memory requester.
//               Data wins by default; instruction fetch is forced through
//               after STARVE_LIMIT consecutive data grants taken while it
//               was waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = C_DEFAULT_ADDR_WIDTH,
    parameter int unsigned BIT_WIDTH    = C_DEFAULT_BIT_WIDTH,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [BIT_WIDTH-1:0]  if_rdata,
    output logic                  if_ack,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [BIT_WIDTH-1:0]  dm_wdata,
    output logic [BIT_WIDTH-1:0]  dm_rdata,
    output logic                  dm_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BIT_WIDTH-1:0]  mem_wdata,
    input  logic [BIT_WIDTH-1:0]  mem_rdata,
    input  logic                  mem_ack
);

    // Counter must be able to hold the value STARVE_LIMIT itself
    localparam int unsigned        C_CNT_W   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(STARVE_LIMIT);

    arb_state_e             state_q,      state_d;
    arb_owner_e             owner_q,      owner_d;
    logic [C_CNT_W-1:0]     starve_cnt_q, starve_cnt_d;
    logic                   mem_we_q,     mem_we_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q,   mem_addr_d;
    logic [BIT_WIDTH-1:0]   mem_wdata_q,  mem_wdata_d;
    logic [BIT_WIDTH-1:0]   if_rdata_q,   if_rdata_d;
    logic [BIT_WIDTH-1:0]   dm_rdata_q,   dm_rdata_d;

    logic                   w_starve_hit;
    logic [C_CNT_W-1:0]     w_cnt_inc;

    // Instruction fetch has waited long enough to pre-empt a data request
    assign w_starve_hit = if_req && (starve_cnt_q == C_CNT_MAX);
    // Saturating increment of the starvation counter
    assign w_cnt_inc    = (starve_cnt_q == C_CNT_MAX) ? C_CNT_MAX : starve_cnt_q + 1'b1;

    // Next-state, grant capture and read-data capture
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (dm_req && !w_starve_hit) begin
                    state_d      = ST_BUSY_D;
                    owner_d      = OWNER_D;
                    mem_we_d     = dm_we;
                    mem_addr_d   = dm_addr;
                    mem_wdata_d  = dm_wdata;
                    // Only data grants that bypass a waiting fetch count as starvation
                    starve_cnt_d = if_req ? w_cnt_inc : '0;
                end else if (if_req) begin
                    state_d      = ST_BUSY_I;
                    owner_d      = OWNER_I;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr;
                    mem_wdata_d  = '0;
                    starve_cnt_d = '0;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (mem_ack) begin
                    state_d = ST_DONE;
                    if (owner_q == OWNER_I) begin
                        if_rdata_d = mem_rdata;
                    end else begin
                        dm_rdata_d = mem_rdata;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_I;
            starve_cnt_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    assign mem_req   = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ack    = (state_q == ST_DONE) && (owner_q == OWNER_I);
    assign dm_ack    = (state_q == ST_DONE) && (owner_q == OWNER_D);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter. A transaction-level
//               model predicts grants and completions; a separate monitor
//               compares the DUT's memory port and acks against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SL     = 4;
    localparam int BUDGET = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    mem_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .BIT_WIDTH    (DW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder configuration: 0 random delay, 1 fixed delay/data, 2 never ack
    int            resp_mode    = 0;
    int            fixed_delay  = 0;
    logic [DW-1:0] fixed_rdata  = '0;
    bit            spurious_en  = 1'b0;
    int            ack_pulse_at = -1;

    typedef struct {
        bit            own_d;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        int            at;
    } req_t;

    typedef struct {
        bit            own_d;
        logic [DW-1:0] rdata;
        bit            chk_rdata;
        int            at;
    } ack_t;

    req_t q_req[$];
    ack_t q_ack[$];

    // Reference model state
    bit            m_in_txn   = 1'b0;
    bit            m_own_d    = 1'b0;
    logic          m_we       = 1'b0;
    int            m_next_ok  = 0;
    int            m_starve   = 0;
    logic [DW-1:0] m_if_rdata = '0;
    logic [DW-1:0] m_dm_rdata = '0;
    bit            m_dm_known = 1'b1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk(act === exp, name, act, exp);
    endtask

    task automatic check_zero(input string tag);
        chk_eq({tag, "_mem_req"},   32'(mem_req),   32'd0);
        chk_eq({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk_eq({tag, "_mem_addr"},  mem_addr,       32'd0);
        chk_eq({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        chk_eq({tag, "_if_ack"},    32'(if_ack),    32'd0);
        chk_eq({tag, "_dm_ack"},    32'(dm_ack),    32'd0);
        chk_eq({tag, "_if_rdata"},  if_rdata,       32'd0);
        chk_eq({tag, "_dm_rdata"},  dm_rdata,       32'd0);
    endtask

    // Predictor: applies the arbitration rules once per edge, just after it
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                m_in_txn   = 1'b0;
                m_next_ok  = 0;
                m_starve   = 0;
                m_if_rdata = '0;
                m_dm_rdata = '0;
                m_dm_known = 1'b1;
            end else if (m_in_txn) begin
                if (mem_ack) begin
                    q_ack.push_back('{own_d: m_own_d, rdata: mem_rdata, chk_rdata: !m_we, at: cyc});
                    if (m_own_d) begin
                        m_dm_rdata = mem_rdata;
                        m_dm_known = !m_we;
                    end else begin
                        m_if_rdata = mem_rdata;
                    end
                    m_in_txn  = 1'b0;
                    m_next_ok = cyc + 2;
                end
            end else if (cyc >= m_next_ok && (if_req || dm_req)) begin
                m_own_d = dm_req && !(if_req && m_starve == SL);
                if (m_own_d) m_starve = if_req ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
                else         m_starve = 0;
                m_we = m_own_d ? dm_we : 1'b0;
                q_req.push_back('{own_d: m_own_d, addr: (m_own_d ? dm_addr : if_addr),
                                  we: m_we, wdata: dm_wdata, at: cyc});
                m_in_txn = 1'b1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request or an ack
    initial begin
        bit   prev_req;
        req_t cur;
        ack_t a;
        prev_req = 1'b0;
        cur      = '{own_d: 1'b0, addr: '0, we: 1'b0, wdata: '0, at: 0};
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                q_req.delete();
                q_ack.delete();
                prev_req = 1'b0;
            end else begin
                if (mem_req && !prev_req) begin
                    chk(q_req.size() != 0, "grant_expected", 32'd0, 32'd1);
                    if (q_req.size() != 0) begin
                        cur = q_req.pop_front();
                        chk_eq("grant_cycle", cyc, cur.at);
                        chk_eq("mem_addr", mem_addr, cur.addr);
                        chk_eq("mem_we", 32'(mem_we), 32'(cur.we));
                        if (cur.own_d) chk_eq("mem_wdata", mem_wdata, cur.wdata);
                    end
                end else if (mem_req) begin
                    chk_eq("mem_addr_stable", mem_addr, cur.addr);
                    chk_eq("mem_we_stable", 32'(mem_we), 32'(cur.we));
                    if (cur.own_d) chk_eq("mem_wdata_stable", mem_wdata, cur.wdata);
                end
                if (if_ack || dm_ack) begin
                    chk(q_ack.size() != 0, "ack_expected", 32'd0, 32'd1);
                    if (q_ack.size() != 0) begin
                        a = q_ack.pop_front();
                        chk_eq("if_ack_owner", 32'(if_ack), 32'(!a.own_d));
                        chk_eq("dm_ack_owner", 32'(dm_ack), 32'(a.own_d));
                        chk_eq("ack_cycle", cyc, a.at);
                        if (a.chk_rdata) chk_eq("ack_rdata", a.own_d ? dm_rdata : if_rdata, a.rdata);
                    end
                end
                chk_eq("if_rdata_hold", if_rdata, m_if_rdata);
                if (m_dm_known) chk_eq("dm_rdata_hold", dm_rdata, m_dm_rdata);
                prev_req = mem_req;
            end
        end
    end

    // Memory responder, plus optional stray acks while the port is idle
    initial begin
        bit busy;
        int wait_n;
        busy      = 1'b0;
        wait_n    = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (rst) begin
                busy = 1'b0;
            end else if (cyc == ack_pulse_at) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
            end else if (mem_req && resp_mode != 2) begin
                if (!busy) begin
                    busy   = 1'b1;
                    wait_n = (resp_mode == 1) ? fixed_delay : int'($urandom_range(0, 3));
                end
                if (wait_n == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = (resp_mode == 1) ? fixed_rdata : $urandom;
                    busy      = 1'b0;
                end else begin
                    wait_n--;
                end
            end else if (!mem_req && spurious_en) begin
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    task automatic if_issue(input logic [AW-1:0] a, input int pre, output int ack_c);
        bit got;
        got = 1'b0;
        @(negedge clk);
        repeat (pre) @(negedge clk);
        if_addr = a;
        if_req  = 1'b1;
        for (int n = 0; n < BUDGET && !got; n++) begin
            @(negedge clk);
            if (if_ack) got = 1'b1;
        end
        if_req = 1'b0;
        ack_c  = cyc;
        chk(got, "if_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic dm_issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int pre, output int ack_c);
        bit got;
        got = 1'b0;
        @(negedge clk);
        repeat (pre) @(negedge clk);
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = d;
        dm_req   = 1'b1;
        for (int n = 0; n < BUDGET && !got; n++) begin
            @(negedge clk);
            if (dm_ack) got = 1'b1;
        end
        dm_req = 1'b0;
        ack_c  = cyc;
        chk(got, "dm_ack_timeout", 32'd0, 32'd1);
    endtask

    // Asynchronous reset pulse, asserted away from any clock edge
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t_i, t_d, d_cnt, d_before, d_after;
        bit seen;
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Data read, memory answers after two wait cycles
        resp_mode   = 1;
        fixed_delay = 2;
        fixed_rdata = 32'hDEADBEEF;
        dm_issue(1'b0, 32'h0000_0100, 32'h0, 0, t_d);
        chk_eq("read_dm_rdata", dm_rdata, 32'hDEADBEEF);
        @(negedge clk);
        chk_eq("read_dm_ack_single", 32'(dm_ack), 32'd0);

        // Simultaneous requests from idle: data first, then fetch
        resp_mode = 0;
        do_reset();
        fork
            if_issue(32'h0000_1000, 0, t_i);
            dm_issue(1'b0, 32'h0000_2000, 32'h0, 0, t_d);
        join
        chk(t_d < t_i, "d_before_i", 32'(t_d), 32'(t_i));

        // Data held continuously with fetch waiting: starvation cut-off
        do_reset();
        @(negedge clk);
        if_addr = 32'h0000_4000; if_req = 1'b1;
        dm_we = 1'b0; dm_addr = 32'h0000_0200; dm_wdata = '0; dm_req = 1'b1;
        d_cnt = 0; d_before = -1; d_after = 0;
        for (int n = 0; n < BUDGET && d_after == 0; n++) begin
            @(negedge clk);
            if (dm_ack) begin
                if (d_before < 0) d_cnt++;
                else d_after++;
            end
            if (if_ack) begin
                d_before = d_cnt;
                if_req   = 1'b0;
            end
        end
        dm_req = 1'b0;
        chk_eq("starve_d_grants", d_before, SL);
        chk_eq("starve_d_resumes", d_after, 1);

        // Write with a long memory stall: operands held, one ack
        resp_mode   = 1;
        fixed_delay = 5;
        dm_issue(1'b1, 32'h0000_0020, 32'h1234_5678, 0, t_d);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (dm_ack) seen = 1'b1;
        end
        chk_eq("write_dm_ack_once", 32'(seen), 32'd0);

        // Randomized traffic with stray acks while idle
        resp_mode   = 0;
        spurious_en = 1'b1;
        for (int it = 0; it < 120; it++) begin
            int m;
            m = int'($urandom_range(0, 2));
            fork
                if (m != 1) if_issue($urandom, int'($urandom_range(0, 3)), t_i);
                if (m != 0) dm_issue(1'($urandom_range(0, 1)), $urandom, $urandom,
                                     int'($urandom_range(0, 3)), t_d);
            join
        end
        spurious_en = 1'b0;

        // Reset during a fetch, then a late ack after release
        repeat (4) @(negedge clk);
        resp_mode = 2;
        if_addr   = 32'h0000_8000;
        if_req    = 1'b1;
        seen      = 1'b0;
        for (int n = 0; n < BUDGET && !seen; n++) begin
            @(negedge clk);
            if (mem_req) seen = 1'b1;
        end
        chk_eq("busy_i_mem_req", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst          = 1'b0;
        ack_pulse_at = cyc + 1;
        resp_mode    = 0;
        seen         = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (if_ack || mem_req) seen = 1'b1;
        end
        chk_eq("late_ack_ignored", 32'(seen), 32'd0);
        check_zero("after_late_ack");

        chk_eq("req_queue_drained", q_req.size(), 32'd0);
        chk_eq("ack_queue_drained", q_ack.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: address width of all address ports.
REQ-002 SHALL have parameter BIT_WIDTH, default 32: data width of all data ports.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data grants while instruction fetch waits.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports if_req (in, 1), if_addr (in, ADDR_WIDTH), if_rdata (out, BIT_WIDTH) and if_ack (out, 1): read-only instruction-fetch requester.
REQ-007 SHALL have ports dm_req (in, 1), dm_we (in, 1), dm_addr (in, ADDR_WIDTH), dm_wdata (in, BIT_WIDTH), dm_rdata (out, BIT_WIDTH) and dm_ack (out, 1): data-memory requester.
REQ-008 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, ADDR_WIDTH), mem_wdata (out, BIT_WIDTH), mem_rdata (in, BIT_WIDTH) and mem_ack (in, 1): single shared memory port.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY_I, BUSY_D and DONE.
REQ-010 SHALL sample requests only in IDLE and ignore request inputs in all other states.
REQ-011 SHALL transition IDLE->BUSY_D when dm_req=1, unless if_req=1 and starve_cnt==STARVE_LIMIT, in which case it SHALL transition IDLE->BUSY_I.
REQ-012 SHALL transition IDLE->BUSY_I when only if_req=1, and remain in IDLE when neither request is asserted.
REQ-013 SHALL register address, we (0 for IF) and wdata from the granted requester on the grant edge; these outputs SHALL stay stable throughout BUSY_x.
REQ-014 SHALL drive mem_req=1 for exactly the BUSY_I and BUSY_D states, holding it until mem_ack=1 is sampled.
REQ-015 SHALL, on the edge where mem_ack=1 in BUSY_x, capture mem_rdata into x_rdata and transition to DONE.
REQ-016 SHALL assert exactly the owner's x_ack for the single DONE cycle, then transition to IDLE.
REQ-017 SHALL hold x_rdata until the next completed transaction for the same requester; rdata captured for a write is don't-care.
REQ-018 SHALL give a minimum latency of: req sampled at edge N, mem_req high from N, ack high during the cycle after mem_ack, and the next grant no earlier than the DONE->IDLE edge plus one.
REQ-019 SHALL increment starve_cnt (saturating at STARVE_LIMIT) on each D grant taken while if_req=1, and clear it on any I grant or any D grant taken while if_req=0.
REQ-020 SHALL ignore mem_ack when in IDLE or DONE.
REQ-021 SHALL expect requesters to hold req and operands stable until their ack and to deassert req in the ack cycle; a req still high in IDLE after DONE SHALL be treated as a new request.

Reset
REQ-022 SHALL, on rst=1, asynchronously force state IDLE, starve_cnt=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=0, dm_ack=0, if_rdata=0 and dm_rdata=0.
REQ-023 SHALL abandon any in-flight transaction on reset without issuing an ack; a late mem_ack after reset release SHALL be ignored per REQ-020.

Structure
REQ-024 SHALL take the FSM state encoding and the default ADDR_WIDTH/BIT_WIDTH constants from the shared mips_pkg package.
REQ-025 SHALL be a single flat module; no sub-module is warranted.

Verification
REQ-026 SHALL cover: dm_req=1, dm_we=0, dm_addr=0x100, memory returning 0xDEADBEEF after 2 cycles -> mem_addr=0x100, mem_we=0, dm_rdata=0xDEADBEEF, and a single-cycle dm_ack.
REQ-027 SHALL cover: if_req and dm_req both asserted from IDLE with starve_cnt=0 -> D granted first, and I granted on the next IDLE.
REQ-028 SHALL cover: dm_req held continuously with if_req=1 and STARVE_LIMIT=4 -> 4 D grants, then 1 I grant, then D resumes.
REQ-029 SHALL cover: dm_we=1, dm_addr=0x20, dm_wdata=0x12345678 with mem_ack delayed 5 cycles -> mem_wdata held stable for all 5 cycles and dm_ack asserted exactly once.
REQ-030 SHALL cover: rst asserted during BUSY_I, followed by mem_ack 1 cycle after release -> state IDLE, all outputs 0, and no if_ack.
